// File: rtl/ps2_key_state_decoder.sv
// ps2_key_state_decoder
// Turns the PS/2 byte stream (make codes, F0 break prefix and, when
// PS2_EXTENDED_EN is defined, the E0 extended prefix) into a held-state
// vector per key, one-cycle press/release pulses and a queue of key events.
// Everything runs in the CLOCK_50 domain.
//
// Build option: define PS2_EXTENDED_EN to compile in E0 handling. Without
// it, E0 is dropped and entries with bit 8 set can never match.
//
// Ports
//   CLOCK_50          system clock
//   resetn            synchronous reset, active HIGH despite the name
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   key_state         1 = key held
//   key_press_pulse   one-cycle pulse on 0->1 of a key
//   key_release_pulse one-cycle pulse on 1->0 of a key
//   any_release_pulse OR of key_release_pulse
//   evt_valid/ready   event queue handshake (pop on valid && ready)
//   evt_key_idx       head event key index
//   evt_is_press      head event kind (1 = press, 0 = release)
//   evt_overflow      sticky, an event was dropped on a full queue
module ps2_key_state_decoder #(
  parameter int NUM_KEYS = 29,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {
    9'h029, 9'h05D, 9'h05B, 9'h054, 9'h04D, 9'h044, 9'h043, 9'h03C,
    9'h035, 9'h02C, 9'h02D, 9'h024, 9'h01D, 9'h015, 9'h00D, 9'h066,
    9'h055, 9'h04E, 9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036, 9'h02E,
    9'h025, 9'h026, 9'h01E, 9'h016, 9'h00E},
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [NUM_KEYS-1:0]         key_state,
  output logic [NUM_KEYS-1:0]         key_press_pulse,
  output logic [NUM_KEYS-1:0]         key_release_pulse,
  output logic                        any_release_pulse,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key_idx,
  output logic                        evt_is_press,
  output logic                        evt_overflow
);

  localparam int IDXW = $clog2(NUM_KEYS);
  localparam int AW   = $clog2(FIFO_DEPTH);

`ifdef PS2_EXTENDED_EN
  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} parserState_t;
`else
  typedef enum logic {IDLE, BREAK} parserState_t;
`endif

  parserState_t state, nextState;

  logic            doLookup, isBreak, lookupExt;
  logic            hit;
  logic [IDXW-1:0] hitIdx;
  logic            pressEvt, releaseEvt, pushReq, pushOk, pop, full;
  logic [AW:0]     wrPtr, rdPtr;
  logic [IDXW:0]   evtMem [FIFO_DEPTH];

  // Parser: decides what the current byte means; state only moves on rx_valid.
  always_comb begin
    nextState = state;
    doLookup  = 1'b0;
    isBreak   = 1'b0;
    lookupExt = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hF0) nextState = BREAK;
`ifdef PS2_EXTENDED_EN
          else if (rx_data == 8'hE0) nextState = EXT;
`else
          else if (rx_data == 8'hE0) nextState = IDLE;
`endif
          // Keyboard status replies (BAT ok, ack, resend, echo) are not keys.
          else if (rx_data == 8'hAA || rx_data == 8'hFA ||
                   rx_data == 8'hFE || rx_data == 8'hEE) nextState = IDLE;
          else doLookup = 1'b1;
        end
        BREAK: begin
          doLookup  = 1'b1;
          isBreak   = 1'b1;
          nextState = IDLE;
        end
`ifdef PS2_EXTENDED_EN
        EXT: begin
          if (rx_data == 8'hF0) nextState = EXT_BREAK;
          else begin
            doLookup  = 1'b1;
            lookupExt = 1'b1;
            nextState = IDLE;
          end
        end
        EXT_BREAK: begin
          doLookup  = 1'b1;
          isBreak   = 1'b1;
          lookupExt = 1'b1;
          nextState = IDLE;
        end
`endif
        default: nextState = IDLE;
      endcase
    end
  end

  // Full 9-bit compare; scanning downwards lets the lowest index win.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[9*i +: 9] == {lookupExt, rx_data}) begin
        hit    = 1'b1;
        hitIdx = IDXW'(i);
      end
    end
  end

  // Typematic repeats and breaks of keys not held produce nothing.
  assign pressEvt   = doLookup && hit && !isBreak && !key_state[hitIdx];
  assign releaseEvt = doLookup && hit &&  isBreak &&  key_state[hitIdx];
  assign pushReq    = pressEvt || releaseEvt;

  assign evt_valid = (wrPtr != rdPtr);
  assign full      = (wrPtr == {~rdPtr[AW], rdPtr[AW-1:0]});
  assign pop       = evt_valid && evt_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign pushOk    = pushReq && (!full || pop);

  assign evt_key_idx       = evtMem[rdPtr[AW-1:0]][IDXW:1];
  assign evt_is_press      = evtMem[rdPtr[AW-1:0]][0];
  assign any_release_pulse = |key_release_pulse;

  always_ff @(posedge CLOCK_50) begin
    if (resetn) begin
      state             <= IDLE;
      key_state         <= '0;
      key_press_pulse   <= '0;
      key_release_pulse <= '0;
      wrPtr             <= '0;
      rdPtr             <= '0;
      evt_overflow      <= 1'b0;
    end else begin
      state             <= nextState;
      key_press_pulse   <= '0;
      key_release_pulse <= '0;
      if (pressEvt) begin
        key_state[hitIdx]       <= 1'b1;
        key_press_pulse[hitIdx] <= 1'b1;
      end
      if (releaseEvt) begin
        key_state[hitIdx]         <= 1'b0;
        key_release_pulse[hitIdx] <= 1'b1;
      end
      if (pop)    rdPtr <= rdPtr + 1'b1;
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pushReq && !pushOk) evt_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn && pushOk) evtMem[wrPtr[AW-1:0]] <= {hitIdx, pressEvt};
  end

endmodule

// File: tb/tb_ps2_key_state_decoder.sv
module tb_ps2_key_state_decoder;

  localparam int NK    = 29;
  localparam int DEPTH = 8;
  // Same piano map but entry 0 replaced by extended 0x75.
  localparam logic [NK*9-1:0] KC2 = {
    9'h029, 9'h05D, 9'h05B, 9'h054, 9'h04D, 9'h044, 9'h043, 9'h03C,
    9'h035, 9'h02C, 9'h02D, 9'h024, 9'h01D, 9'h015, 9'h00D, 9'h066,
    9'h055, 9'h04E, 9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036, 9'h02E,
    9'h025, 9'h026, 9'h01E, 9'h016, 9'h175};
`ifdef PS2_EXTENDED_EN
  localparam bit EXT_ON = 1'b1;
`else
  localparam bit EXT_ON = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic          resetn, rx_valid, evt_ready;
  logic [7:0]    rx_data;
  logic [NK-1:0] key_state, key_press_pulse, key_release_pulse;
  logic          any_release_pulse, evt_valid, evt_is_press, evt_overflow;
  logic [4:0]    evt_key_idx;
  logic [NK-1:0] ks2, kp2, kr2;
  logic          any2, ev2, isp2, ovf2;
  logic [4:0]    idx2;

  ps2_key_state_decoder dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_state(key_state), .key_press_pulse(key_press_pulse),
    .key_release_pulse(key_release_pulse), .any_release_pulse(any_release_pulse),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key_idx(evt_key_idx),
    .evt_is_press(evt_is_press), .evt_overflow(evt_overflow));

  ps2_key_state_decoder #(.KEY_CODES(KC2)) dut2 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_state(ks2), .key_press_pulse(kp2), .key_release_pulse(kr2),
    .any_release_pulse(any2), .evt_valid(ev2), .evt_ready(evt_ready),
    .evt_key_idx(idx2), .evt_is_press(isp2), .evt_overflow(ovf2));

  int nCmp = 0;
  int nErr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (key table + event list) ----------------
  int unsigned mapCode[NK] = '{'h0E, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D,
    'h3E, 'h46, 'h45, 'h4E, 'h55, 'h66, 'h0D, 'h15, 'h1D, 'h24, 'h2D, 'h2C,
    'h35, 'h3C, 'h43, 'h44, 'h4D, 'h54, 'h5B, 'h5D, 'h29};
  typedef struct {int idx; bit press;} evt_t;
  evt_t          mQ[$];
  logic [NK-1:0] mHeld, mPress, mRel;
  bit            mOvf, mBrk, mExt;

  // Default map has no extended entries, so any extended lookup misses.
  function automatic int findKey(input bit ex, input logic [7:0] d);
    if (ex) return -1;
    for (int i = 0; i < NK; i++) if (mapCode[i] == d) return i;
    return -1;
  endfunction

  task automatic modelCycle(input bit rst, input bit vld, input logic [7:0] d, input bit rdy);
    bit look, brk, ex;
    int k;
    evt_t e;
    mPress = '0;
    mRel   = '0;
    if (rst) begin
      mQ.delete(); mHeld = '0; mOvf = 0; mBrk = 0; mExt = 0;
      return;
    end
    if (rdy && mQ.size() > 0) void'(mQ.pop_front());
    if (!vld) return;
    look = 0; brk = 0; ex = 0;
    if (mBrk) begin
      look = 1; brk = 1; ex = mExt; mBrk = 0; mExt = 0;
    end else if (mExt) begin
      if (d == 8'hF0) mBrk = 1;
      else begin look = 1; ex = 1; mExt = 0; end
    end else if (d == 8'hF0) mBrk = 1;
    else if (d == 8'hE0) mExt = EXT_ON;
    else if (d == 8'hAA || d == 8'hFA || d == 8'hFE || d == 8'hEE) look = 0;
    else look = 1;
    if (!look) return;
    k = findKey(ex, d);
    if (k < 0) return;
    if (!brk && !mHeld[k]) begin
      mHeld[k] = 1; mPress[k] = 1; e = '{k, 1'b1};
    end else if (brk && mHeld[k]) begin
      mHeld[k] = 0; mRel[k] = 1; e = '{k, 1'b0};
    end else return;
    if (mQ.size() < DEPTH) mQ.push_back(e);
    else mOvf = 1;
  endtask

  task automatic compareAll();
    chk("key_state", key_state, mHeld);
    chk("press_pulse", key_press_pulse, mPress);
    chk("release_pulse", key_release_pulse, mRel);
    chk("any_release", any_release_pulse, |mRel);
    chk("evt_valid", evt_valid, mQ.size() > 0);
    chk("evt_overflow", evt_overflow, mOvf);
    if (mQ.size() > 0) begin
      chk("evt_key_idx", evt_key_idx, mQ[0].idx);
      chk("evt_is_press", evt_is_press, mQ[0].press);
    end
  endtask

  task automatic step(input bit rst, input bit vld, input logic [7:0] d, input bit rdy);
    resetn = rst; rx_valid = vld; rx_data = d; evt_ready = rdy;
    modelCycle(rst, vld, d, rdy);
    @(posedge CLOCK_50);
    #1;
    compareAll();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst; bit vld; logic [7:0] d; bit rdy;
    int idx; bit st; bit pr; bit rl; bit any; bit ev;
  } vec_t;
  vec_t tbl[15];

  initial begin
    //          rst vld data   rdy idx st pr rl any ev
    tbl[0]  = '{1, 0, 8'h00, 0, 15, 0, 0, 0, 0, 0};  // reset state
    tbl[1]  = '{0, 1, 8'h15, 0, 15, 1, 1, 0, 0, 1};  // make Q
    tbl[2]  = '{0, 0, 8'h00, 0, 15, 1, 0, 0, 0, 1};  // pulse lasts one cycle
    tbl[3]  = '{0, 1, 8'h15, 0, 15, 1, 0, 0, 0, 1};  // typematic
    tbl[4]  = '{0, 1, 8'h15, 0, 15, 1, 0, 0, 0, 1};  // typematic
    tbl[5]  = '{0, 0, 8'h00, 1, 15, 1, 0, 0, 0, 0};  // single event popped
    tbl[6]  = '{0, 1, 8'hF0, 0, 15, 1, 0, 0, 0, 0};  // prefix: no change
    tbl[7]  = '{0, 1, 8'h15, 0, 15, 0, 0, 1, 1, 1};  // break Q
    tbl[8]  = '{0, 0, 8'h00, 0, 15, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 8'h00, 1, 15, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 8'hF0, 0, 28, 0, 0, 0, 0, 0};  // pending break...
    tbl[11] = '{1, 0, 8'h00, 0, 28, 0, 0, 0, 0, 0};  // ...discarded by reset
    tbl[12] = '{0, 1, 8'h29, 0, 28, 1, 1, 0, 0, 1};  // so 29 is a make
    tbl[13] = '{0, 1, 8'hF0, 0, 28, 1, 0, 0, 0, 1};  // back-to-back bytes
    tbl[14] = '{0, 1, 8'h29, 0, 28, 0, 0, 1, 1, 1};

    resetn = 1; rx_valid = 0; rx_data = 0; evt_ready = 0;
    mHeld = '0; mPress = '0; mRel = '0; mOvf = 0; mBrk = 0; mExt = 0;
    @(posedge CLOCK_50); #1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_state", i), key_state[tbl[i].idx], tbl[i].st);
      chk($sformatf("tbl%0d_press", i), key_press_pulse[tbl[i].idx], tbl[i].pr);
      chk($sformatf("tbl%0d_rel", i), key_release_pulse[tbl[i].idx], tbl[i].rl);
      chk($sformatf("tbl%0d_any", i), any_release_pulse, tbl[i].any);
      chk($sformatf("tbl%0d_evv", i), evt_valid, tbl[i].ev);
    end

    // Overflow: nine distinct makes into an 8-deep queue, then drain.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 8'(mapCode[i]), 0);
    chk("ovf_key_state", key_state, 29'h1FF);
    chk("ovf_flag", evt_overflow, 1'b1);
    chk("ovf_head_idx", evt_key_idx, 5'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_idx", i), evt_key_idx, 5'(i));
      step(0, 0, 8'h00, 1);
    end
    chk("drain_empty", evt_valid, 1'b0);
    chk("ovf_sticky", evt_overflow, 1'b1);

    // Full queue with simultaneous pop accepts the new push.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'(mapCode[i]), 0);
    step(0, 1, 8'(mapCode[20]), 1);
    chk("fullpop_ovf", evt_overflow, 1'b0);

    // Extended entry on the second instance.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h75, 0);
    chk("ext_plain75", ks2[0], 1'b0);
    step(0, 1, 8'hE0, 0);
    chk("ext_prefix_quiet", ks2[0], 1'b0);
    step(0, 1, 8'h75, 0);
    chk("ext_e0_75", ks2[0], EXT_ON);

    // Randomized traffic against the model.
    step(1, 0, 8'h00, 0);
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] b;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: b = 8'(mapCode[$urandom_range(0, NK - 1)]);
        5: b = 8'hF0;
        6: b = 8'hE0;
        7: begin
          int s;
          s = $urandom_range(0, 3);
          b = (s == 0) ? 8'hAA : (s == 1) ? 8'hFA : (s == 2) ? 8'hFE : 8'hEE;
        end
        8: b = 8'($urandom);
        default: b = 8'h75;
      endcase
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 6, b,
           $urandom_range(0, 9) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
